adder_tree_seq: RTL and testbench

Frame sequencer for the 8-lane `adder_tree` accumulator. It holds one frame of BEATS x 8 samples in a local buffer loaded through a write port. On `start` it clears the tree, streams the frame into it one beat per cycle, waits out the tree pipeline, then captures the 32-bit total and a rounded 8-bit mean. It sits between the sample source and `adder_tree`, and replaces free-running testbench-style feeding with a start/done handshake.

---
 rtl/adder_tree_pkg.sv | 13 +
 rtl/frame_buf.sv | 20 ++
 rtl/adder_tree_seq.sv | 89 ++++++++
 tb/tb_adder_tree_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared types, widths and mean rounding for the adder_tree frame sequencer
package adder_tree_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_DONE} seq_state_t;
  localparam int LANES = 8;
  localparam int LANE_W = 8;
  localparam int DATA_W = LANES * LANE_W;
  localparam int SUM_W = 32;
  function automatic logic [LANE_W-1:0] round_mean(input logic [SUM_W-1:0] sum, input int sh);
    logic [SUM_W:0] r;
    r = ({1'b0, sum} + ((SUM_W+1)'(1) << (sh - 1))) >> sh;
    return (r > (SUM_W+1)'(255)) ? '1 : r[LANE_W-1:0];
  endfunction
endpackage

// File: rtl/frame_buf.sv
// frame_buf: one-frame sample store with a synchronous write port and a combinational read port
module frame_buf
  import adder_tree_pkg::*;
#(
  parameter int BEATS = 32,
  localparam int AW = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [BEATS];
  // contents deliberately survive reset so a frame can be rerun after an abort
  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/adder_tree_seq.sv
// adder_tree_seq: clears the adder tree, streams one buffered frame into it and captures total and mean
module adder_tree_seq
  import adder_tree_pkg::*;
#(
  parameter int BEATS = 32,
  parameter int TREE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(BEATS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [SUM_W-1:0]         sum_out,
  output logic [LANE_W-1:0]        avg,
  output logic                     wr_drop,
  output logic                     tree_clr,
  output logic                     tree_valid,
  output logic [DATA_W-1:0]        tree_data,
  input  logic [SUM_W-1:0]         tree_sum
);
  localparam int AW = $clog2(BEATS);
  localparam int SH = $clog2(LANES * BEATS);
  seq_state_t state_q, state_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [3:0] lat_q, lat_d;
  logic [DATA_W-1:0] rd_data;
  frame_buf #(.BEATS(BEATS)) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en & ~busy),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (beat_d),
    .rd_data_o (rd_data)
  );
  // next state and counters; outputs are registered from the next state so they align with it
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    lat_d = lat_q;
    case (state_q)
      S_IDLE: state_d = start ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        state_d = S_STREAM;
        beat_d = '0;
      end
      S_STREAM: begin
        beat_d = beat_q + 1'b1;
        lat_d = '0;
        state_d = (beat_q == AW'(BEATS - 1)) ? S_DRAIN : S_STREAM;
      end
      S_DRAIN: begin
        lat_d = lat_q + 1'b1;
        state_d = (lat_q == 4'(TREE_LAT - 1)) ? S_DONE : S_DRAIN;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state, counters and all registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      beat_q <= '0;
      lat_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sum_out <= '0;
      avg <= '0;
      wr_drop <= 1'b0;
      tree_clr <= 1'b0;
      tree_valid <= 1'b0;
      tree_data <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      lat_q <= lat_d;
      busy <= state_d != S_IDLE;
      done <= state_d == S_DONE;
      sum_out <= (state_d == S_DONE) ? tree_sum : sum_out;
      avg <= (state_d == S_DONE) ? round_mean(tree_sum, SH) : avg;
      wr_drop <= wr_en & busy;
      tree_clr <= state_d == S_CLEAR;
      tree_valid <= state_d == S_STREAM;
      tree_data <= (state_d == S_STREAM) ? rd_data : '0;
    end
endmodule

// File: tb/tb_adder_tree_seq.sv
// tb_adder_tree_seq: randomized frame passes against a byte-sum reference and a pipelined tree model
module tb_adder_tree_seq;
  localparam int BEATS = 32;
  localparam int TREE_LAT = 3;
  localparam int AW = $clog2(BEATS);
  localparam int SH = $clog2(8 * BEATS);
  localparam int FRAME_LAT = 2 + BEATS + TREE_LAT;
  logic clk = 0, rst = 1, wr_en = 0, start = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic busy, done, wr_drop, tree_clr, tree_valid;
  logic [31:0] sum_out, tree_sum;
  logic [7:0] avg;
  logic [63:0] tree_data;
  logic [31:0] stage [TREE_LAT];
  logic [63:0] ref_buf [BEATS];
  int tests = 0, fails = 0, cyc_g = 0;

  adder_tree_seq #(.BEATS(BEATS), .TREE_LAT(TREE_LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .sum_out(sum_out), .avg(avg),
    .wr_drop(wr_drop), .tree_clr(tree_clr), .tree_valid(tree_valid),
    .tree_data(tree_data), .tree_sum(tree_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  function automatic logic [31:0] lane_total(input logic [63:0] d);
    logic [31:0] t = 0;
    for (int k = 0; k < 8; k++) t += 32'(d[8*k +: 8]);
    return t;
  endfunction

  // adder tree stand-in: accumulator followed by a delay line, total final TREE_LAT cycles after the last beat
  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < TREE_LAT; i++) stage[i] <= '0;
    else begin
      stage[0] <= tree_clr ? 32'd0 : tree_valid ? stage[0] + lane_total(tree_data) : stage[0];
      for (int i = 1; i < TREE_LAT; i++) stage[i] <= stage[i-1];
    end
  assign tree_sum = stage[TREE_LAT-1];

  function automatic longint ref_sum();
    longint s = 0;
    for (int b = 0; b < BEATS; b++)
      for (int k = 0; k < 8; k++) s += longint'(ref_buf[b][8*k +: 8]);
    return s;
  endfunction

  function automatic int ref_avg(input longint s);
    longint r = (s + (longint'(1) << (SH - 1))) >> SH;
    return r > 255 ? 255 : int'(r);
  endfunction

  task automatic wr(input int addr, input logic [63:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = AW'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 0;
    ref_buf[addr] = d;
  endtask

  task automatic fill(input logic [63:0] d);
    for (int b = 0; b < BEATS; b++) wr(b, d);
  endtask

  task automatic run_frame(input bit w, input logic [63:0] wd, output logic [31:0] s, output logic [7:0] a,
                           output int lat, output int nvalid, output int nclr, output int dcyc);
    @(negedge clk);
    start = 1;
    if (w) begin wr_en = 1; wr_addr = '0; wr_data = wd; ref_buf[0] = wd; end
    @(negedge clk);
    start = 0; wr_en = 0;
    lat = 1; nvalid = 0; nclr = 0;
    while (!done && lat < 200) begin
      nvalid += int'(tree_valid);
      nclr += int'(tree_clr);
      @(negedge clk);
      lat++;
    end
    s = sum_out; a = avg; dcyc = cyc_g;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, done, sum_out, avg, wr_drop, tree_clr, tree_valid, tree_data} !== '0) begin
      fails++; $display("FAIL reset_outputs: busy=%b done=%b sum=%0d avg=%0d valid=%b required all 0", busy, done, sum_out, avg, tree_valid);
    end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_ones();
    logic [31:0] s; logic [7:0] a; int lat, nv, nc, dc;
    fill({8{8'h01}});
    run_frame(0, '0, s, a, lat, nv, nc, dc);
    tests++; if (lat !== FRAME_LAT) begin fails++; $display("FAIL ones_latency: got %0d required %0d", lat, FRAME_LAT); end
    tests++; if (s !== 32'd256) begin fails++; $display("FAIL ones_sum: got %0d required 256", s); end
    tests++; if (a !== 8'd1) begin fails++; $display("FAIL ones_avg: got %0d required 1", a); end
    tests++; if (nv !== BEATS) begin fails++; $display("FAIL ones_beats: got %0d required %0d", nv, BEATS); end
    tests++; if (nc !== 1) begin fails++; $display("FAIL ones_clr: got %0d required 1", nc); end
  endtask

  task automatic test_max();
    logic [31:0] s; logic [7:0] a; int lat, nv, nc, dc;
    fill({8{8'hFF}});
    run_frame(0, '0, s, a, lat, nv, nc, dc);
    tests++; if (s !== 32'd65280) begin fails++; $display("FAIL max_sum: got %0d required 65280", s); end
    tests++; if (a !== 8'd255) begin fails++; $display("FAIL max_avg: got %0d required 255", a); end
  endtask

  task automatic test_rounding();
    logic [31:0] s, s2; logic [7:0] a, a2; int lat, nv, nc, dc;
    fill({8{8'h01}});
    wr(0, {{7{8'h01}}, 8'h80});
    run_frame(0, '0, s, a, lat, nv, nc, dc);
    tests++; if (s !== 32'd383 || a !== 8'd1) begin fails++; $display("FAIL round_383: got sum %0d avg %0d required 383 avg 1", s, a); end
    wr(0, {{7{8'h01}}, 8'h81});
    run_frame(0, '0, s, a, lat, nv, nc, dc);
    tests++; if (s !== 32'd384 || a !== 8'd2) begin fails++; $display("FAIL round_384: got sum %0d avg %0d required 384 avg 2", s, a); end
    run_frame(0, '0, s2, a2, lat, nv, nc, dc);
    tests++; if (s2 !== 32'd384 || nc !== 1) begin fails++; $display("FAIL rerun_clear: got sum %0d clr %0d required 384 clr 1", s2, nc); end
  endtask

  task automatic test_random();
    logic [31:0] s; logic [7:0] a; int lat, nv, nc, dc;
    longint es;
    for (int it = 0; it < 4; it++) begin
      for (int b = 0; b < BEATS; b++)
        wr(b, ($urandom_range(0, 3) == 0) ? {8{8'hFF}} : {$urandom, $urandom});
      run_frame(it == 3, {$urandom, $urandom}, s, a, lat, nv, nc, dc);
      es = ref_sum();
      tests++; if (s !== 32'(es)) begin fails++; $display("FAIL random_sum[%0d]: got %0d required %0d", it, s, es); end
      tests++; if (int'(a) !== ref_avg(es)) begin fails++; $display("FAIL random_avg[%0d]: got %0d required %0d", it, a, ref_avg(es)); end
      tests++; if (lat !== FRAME_LAT || nv !== BEATS) begin fails++; $display("FAIL random_timing[%0d]: got lat %0d beats %0d required %0d %0d", it, lat, nv, FRAME_LAT, BEATS); end
    end
  endtask

  task automatic test_write_busy();
    logic [31:0] s; logic [7:0] a; int lat, nv, nc, dc, ndone;
    longint es;
    es = ref_sum();
    ndone = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 1; c <= 90; c++) begin
      if (c == 12) begin wr_en = 1; wr_addr = AW'($urandom_range(0, BEATS - 1)); wr_data = {$urandom, $urandom} | 64'h1; end
      if (c == 13) begin
        wr_en = 0;
        tests++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL drop_pulse: got %b required 1", wr_drop); end
      end
      if (c == 14) begin tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL drop_width: got %b required 0", wr_drop); end end
      if (c == 35) start = 1;
      if (c == 36) start = 0;
      if (c == 38) begin tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_fall: got %b required 0", busy); end end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          tests++; if (c !== FRAME_LAT || sum_out !== 32'(es)) begin fails++; $display("FAIL busy_frame: got cycle %0d sum %0d required %0d %0d", c, sum_out, FRAME_LAT, es); end
        end
      end
      @(negedge clk);
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL drain_start: got %0d done pulses required 1", ndone); end
    run_frame(0, '0, s, a, lat, nv, nc, dc);
    tests++; if (s !== 32'(es)) begin fails++; $display("FAIL drop_buffer: got %0d required %0d", s, es); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic [7:0] a; int lat, nv, nc, dc;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (16) @(negedge clk);
    tests++; if (tree_valid !== 1'b1) begin fails++; $display("FAIL mid_valid: got %b required 1", tree_valid); end
    rst = 1;
    #1;
    tests++;
    if ({busy, done, sum_out, avg, wr_drop, tree_clr, tree_valid, tree_data} !== '0) begin
      fails++; $display("FAIL mid_reset: busy=%b done=%b sum=%0d avg=%0d valid=%b data=%h required all 0", busy, done, sum_out, avg, tree_valid, tree_data);
    end
    @(negedge clk); rst = 0;
    run_frame(0, '0, s, a, lat, nv, nc, dc);
    tests++; if (s !== 32'(ref_sum()) || lat !== FRAME_LAT) begin fails++; $display("FAIL after_reset: got sum %0d lat %0d required %0d %0d", s, lat, ref_sum(), FRAME_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1, s2; logic [7:0] a; int lat, nv1, nv2, nc, d1, d2;
    run_frame(0, '0, s1, a, lat, nv1, nc, d1);
    run_frame(0, '0, s2, a, lat, nv2, nc, d2);
    tests++; if (d2 - d1 !== FRAME_LAT + 1) begin fails++; $display("FAIL b2b_period: got %0d required %0d", d2 - d1, FRAME_LAT + 1); end
    tests++; if (nv1 !== BEATS || nv2 !== BEATS) begin fails++; $display("FAIL b2b_beats: got %0d/%0d required %0d", nv1, nv2, BEATS); end
    tests++; if (s1 !== 32'(ref_sum()) || s2 !== 32'(ref_sum())) begin fails++; $display("FAIL b2b_sum: got %0d/%0d required %0d", s1, s2, ref_sum()); end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_max();
    test_rounding();
    test_random();
    test_write_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
